vl_tx_frame_serializer: RTL and testbench
=========================================

Name: vl_tx_frame_serializer

Overview:
- Parametrised multi-lane successor to the single-lane TX back end (Manchester encode, sync header insertion, serialise), in one clock domain.
- Takes post-RS byte words through a valid/ready handshake and emits a framed Manchester chip stream on LANES parallel optical outputs.
- Chip rate is set by a runtime baud divider instead of a separate serial clock.
- Sits between the RS encoder output and the LED driver pins.

Parameters:
- LANES, 1, number of parallel output lanes (1, 2 or 4); each lane carries one byte of the input word.
- HDR_WORDS, 2, number of 16-chip sync header words sent before the payload.
- HDR_PATTERN, 16'hAAAB, header chip pattern, MSB first, driven identically on all lanes.
- GAP_CHIPS, 32, idle chips forced after each frame before the next header may start (minimum 1).
- IDLE_LEVEL, 1'b0, o_tx level while idle, in gap, or after abort.

Ports:
- i_vl_tx_clk  in  1  clock
- i_vl_tx_rst_n  in  1  async active-low reset
- i_baud_div  in  16  chip period minus 1, in clock cycles; sampled at frame start
- i_val  in  1  input word valid
- i_sof  in  1  first word of frame
- i_eof  in  1  last word of frame
- i_data  in  8*LANES  payload; lane k uses bits [8k+7:8k]
- o_rdy  out  1  word accepted when i_val&o_rdy
- o_tx  out  LANES  chip outputs
- o_tx_en  out  1  high while header/payload/CRC chips are driven
- o_busy  out  1  FSM not IDLE
- o_frame_done  out  1  1-cycle pulse after the last payload/CRC chip completes
- o_underrun  out  1  1-cycle pulse on frame abort
- o_sof_err  out  1  1-cycle pulse when a non-sof word arrives in IDLE, or sof arrives mid-frame

Behaviour:
- Reset (async, active-low, on i_vl_tx_rst_n; clock i_vl_tx_clk): FSM=IDLE, o_tx={LANES{IDLE_LEVEL}}, o_tx_en=0, o_busy=0, o_rdy=0, all pulses 0, counters and holding register cleared. o_rdy rises one cycle after reset deasserts.
- Datapath: one holding register plus one per-lane 16-chip shift register. o_rdy = ~hold_full, except o_rdy=0 in GAP and while the CRC is being appended.
- Manchester encoding: data bit 1 -> chips "10", bit 0 -> chips "01"; byte MSB first, 16 chips per byte.
- Baud tick: counter counts 0..div_latched and ticks at div_latched; it restarts at 0 on every chip load. Each chip is held exactly div_latched+1 cycles. div=0 gives one chip per cycle.
- IDLE:
  - A word with i_sof=1 is accepted into the holding register and div is latched. Next cycle the FSM enters HDR, o_tx_en=1, o_busy=1, and the first header chip is on o_tx.
  - A non-sof word is accepted, dropped, and pulses o_sof_err.
- HDR: HDR_WORDS*16 chips of HDR_PATTERN, then PAY.
- PAY:
  - At each 16-chip boundary the holding register is loaded into the shifters and frees next cycle.
  - A word with i_eof=1 marks the last word. Once its 16 chips finish, the FSM goes to CRC (if enabled) or GAP, with an o_frame_done pulse.
  - A single-word frame (sof and eof together) is legal.
  - i_sof=1 mid-frame: the word is treated as data and o_sof_err pulses.
- Underrun: at a 16-chip boundary in PAY with the holding register empty and eof not yet seen:
  - o_underrun pulses, o_tx goes to IDLE_LEVEL, o_tx_en=0, FSM enters GAP.
  - Remaining words of that frame arriving later are dropped until the next sof; no o_sof_err is raised for them.
- GAP: o_tx=IDLE_LEVEL for GAP_CHIPS chip periods, then IDLE. o_busy falls on entry to IDLE.
- Simultaneous events:
  - Load and accept in the same cycle is legal (the holding register is refilled in the same cycle it drains).
  - Reset mid-frame returns to the reset state immediately; no pulses are produced.
- i_baud_div changes mid-frame have no effect until the next frame.

Optional Feature:
- VL_TX_CRC16_EN defined:
  - CRC-16-CCITT (poly 0x1021, init 0xFFFF, no reflection) is computed over payload bytes in order lane0, lane1, ... per word.
  - After the eof word, FSM state CRC appends the CRC, then o_frame_done pulses and the FSM goes to GAP.
  - LANES=1: two words, high byte then low byte.
  - LANES>=2: one word, lane0=high, lane1=low, other lanes 8'h00.
  - The CRC is not sent on an aborted frame.
- Undefined: no CRC state; the frame ends right after the eof word.

Test Plan:
- LANES=1, div=0, one sof+eof word 8'hA5 -> o_tx: 0xAAAB x2 (32 chips), then 1001100101100110, then o_frame_done; o_tx_en high for exactly 48 cycles.
- div=3, 4-word frame with continuous valid -> each chip held 4 cycles; no o_underrun; o_busy high for (32+64+GAP_CHIPS)*4 cycles plus 1.
- Valid dropped for 40 cycles after word 2 at div=0 -> o_underrun at the next 16-chip boundary; o_tx=IDLE_LEVEL; late words dropped; a following sof frame transmits correctly.
- Non-sof word in IDLE, then sof inside a frame -> o_sof_err pulses twice; the mid-frame word is transmitted as data.
- LANES=4, word 32'h04030201 -> lanes 0..3 carry Manchester of 01,02,03,04 simultaneously; header on all lanes.
- VL_TX_CRC16_EN, LANES=1, payload ASCII "123456789" -> appended CRC chips encode 0x29B1; reset asserted mid-CRC -> outputs at reset values and no o_frame_done.

Source files
------------

// File: rtl/vl_tx_frame_serializer.sv
// Multi-lane Manchester TX framer: sync header, payload, inter-frame gap, runtime baud divider.
// Optional build macro VL_TX_CRC16_EN appends a CRC-16-CCITT trailer after the payload.
module vl_tx_frame_serializer #(
  parameter int          LANES       = 1,
  parameter int          HDR_WORDS   = 2,
  parameter logic [15:0] HDR_PATTERN = 16'hAAAB,
  parameter int          GAP_CHIPS   = 32,
  parameter logic        IDLE_LEVEL  = 1'b0
) (
  input  logic               i_vl_tx_clk,
  input  logic               i_vl_tx_rst_n,
  input  logic [15:0]        i_baud_div,
  input  logic               i_val,
  input  logic               i_sof,
  input  logic               i_eof,
  input  logic [8*LANES-1:0] i_data,
  output logic               o_rdy,
  output logic [LANES-1:0]   o_tx,
  output logic               o_tx_en,
  output logic               o_busy,
  output logic               o_frame_done,
  output logic               o_underrun,
  output logic               o_sof_err
);

  // state | meaning
  // IDLE  | waiting for a sof word
  // HDR   | sending HDR_WORDS copies of HDR_PATTERN
  // PAY   | sending payload words from the holding register
  // CRC   | appending the CRC trailer (VL_TX_CRC16_EN builds only)
  // GAP   | forced idle chips before the next frame

  localparam int W  = 8*LANES;
  localparam int GW = $clog2(GAP_CHIPS+1);
`ifdef VL_TX_CRC16_EN
  localparam int CRC_WORDS = (LANES == 1) ? 2 : 1;
`endif

  typedef enum logic [2:0] {
    S_IDLE = 3'd0,
    S_HDR  = 3'd1,
    S_PAY  = 3'd2,
`ifdef VL_TX_CRC16_EN
    S_CRC  = 3'd4,
`endif
    S_GAP  = 3'd3
  } state_t;

  state_t state, state_nxt;

  logic [W-1:0]            hold;
  logic                    hold_full, hold_last;
  logic                    last_loaded, eof_seen, drop, alive;
  logic [15:0]             div_lat, baud_cnt;
  logic [3:0]              chip_cnt;
  logic [7:0]              word_cnt;
  logic [GW-1:0]           gap_cnt;
  logic [LANES-1:0][15:0]  shreg;
  logic                    frame_done_q, underrun_q, sof_err_q;

  logic accept, tick, boundary, gap_done, tx_active, start, keep;
  logic load_hdr, load_pay, do_done, do_underrun;

  function automatic logic [15:0] manchester(input logic [7:0] b);
    logic [15:0] r;
    r = '0;
    for (int i = 0; i < 8; i++) r[2*i +: 2] = b[i] ? 2'b10 : 2'b01;
    return r;
  endfunction

`ifdef VL_TX_CRC16_EN
  logic [15:0] crc;
  logic [W-1:0] crc_word;
  logic load_crc;

  // Bytes are folded in lane order, MSB first, poly 0x1021.
  function automatic logic [15:0] crc_upd(input logic [15:0] c, input logic [W-1:0] d);
    logic [15:0] r;
    r = c;
    for (int k = 0; k < LANES; k++)
      for (int b = 7; b >= 0; b--)
        r = {r[14:0], 1'b0} ^ ((r[15] ^ d[8*k+b]) ? 16'h1021 : 16'h0000);
    return r;
  endfunction

  // Single lane sends high byte (loaded from PAY) then low byte (loaded from CRC).
  generate
    if (LANES == 1) begin : g_crc1
      assign crc_word = (state == S_PAY) ? crc[15:8] : crc[7:0];
    end else begin : g_crcn
      assign crc_word = W'({crc[7:0], crc[15:8]});
    end
  endgenerate
`endif

  assign tx_active = (state == S_HDR) || (state == S_PAY)
`ifdef VL_TX_CRC16_EN
                     || (state == S_CRC)
`endif
                     ;
  assign accept   = i_val & o_rdy;
  assign tick     = (baud_cnt == div_lat);
  assign boundary = tx_active & tick & (chip_cnt == 4'd15);
  assign gap_done = (gap_cnt == GW'(GAP_CHIPS));
  assign start    = (state == S_IDLE) & accept & i_sof;
  assign keep     = start | (accept & ((state == S_HDR) | (state == S_PAY)));

  always_ff @(posedge i_vl_tx_clk or negedge i_vl_tx_rst_n) begin
    if (!i_vl_tx_rst_n) state <= S_IDLE;
    else                state <= state_nxt;
  end

  always_comb begin
    state_nxt   = state;
    load_hdr    = 1'b0;
    load_pay    = 1'b0;
    do_done     = 1'b0;
    do_underrun = 1'b0;
`ifdef VL_TX_CRC16_EN
    load_crc    = 1'b0;
`endif
    case (state)
      S_IDLE: if (start) state_nxt = S_HDR;
      S_HDR: if (boundary) begin
        if (word_cnt == 8'(HDR_WORDS-1)) begin
          load_pay  = 1'b1;
          state_nxt = S_PAY;
        end else begin
          load_hdr = 1'b1;
        end
      end
      S_PAY: if (boundary) begin
        if (last_loaded) begin
`ifdef VL_TX_CRC16_EN
          load_crc  = 1'b1;
          state_nxt = S_CRC;
`else
          do_done   = 1'b1;
          state_nxt = S_GAP;
`endif
        end else if (hold_full) begin
          load_pay = 1'b1;
        end else begin
          do_underrun = 1'b1;
          state_nxt   = S_GAP;
        end
      end
`ifdef VL_TX_CRC16_EN
      S_CRC: if (boundary) begin
        if (word_cnt == 8'(CRC_WORDS-1)) begin
          do_done   = 1'b1;
          state_nxt = S_GAP;
        end else begin
          load_crc = 1'b1;
        end
      end
`endif
      S_GAP: if (gap_done) state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  always_comb begin
    o_tx_en = tx_active;
    o_busy  = (state != S_IDLE);
    // Once the eof word is taken nothing more belongs to this frame.
    o_rdy   = alive & ~hold_full & ~eof_seen & (state != S_GAP)
`ifdef VL_TX_CRC16_EN
              & (state != S_CRC)
`endif
              ;
    o_tx    = {LANES{IDLE_LEVEL}};
    for (int k = 0; k < LANES; k++) o_tx[k] = tx_active ? shreg[k][15] : IDLE_LEVEL;
  end

  assign o_frame_done = frame_done_q;
  assign o_underrun   = underrun_q;
  assign o_sof_err    = sof_err_q;

  always_ff @(posedge i_vl_tx_clk or negedge i_vl_tx_rst_n) begin
    if (!i_vl_tx_rst_n) begin
      alive        <= 1'b0;
      hold         <= '0;
      hold_full    <= 1'b0;
      hold_last    <= 1'b0;
      last_loaded  <= 1'b0;
      eof_seen     <= 1'b0;
      drop         <= 1'b0;
      div_lat      <= '0;
      baud_cnt     <= '0;
      chip_cnt     <= '0;
      word_cnt     <= '0;
      gap_cnt      <= '0;
      shreg        <= '0;
      frame_done_q <= 1'b0;
      underrun_q   <= 1'b0;
      sof_err_q    <= 1'b0;
    end else begin
      alive        <= 1'b1;
      frame_done_q <= do_done;
      underrun_q   <= do_underrun;
      // Words trailing an aborted frame are discarded silently until the next sof.
      sof_err_q    <= accept & (((state == S_IDLE) & ~i_sof & ~drop) |
                                (((state == S_HDR) | (state == S_PAY)) & i_sof));

      if (start) div_lat <= i_baud_div;

      if (start || tick || (state == S_IDLE)) baud_cnt <= '0;
      else                                    baud_cnt <= baud_cnt + 16'd1;

      if (start)                 chip_cnt <= '0;
      else if (tx_active & tick) chip_cnt <= chip_cnt + 4'd1;

      if (start)         word_cnt <= '0;
      else if (boundary) word_cnt <= (state_nxt == state) ? word_cnt + 8'd1 : 8'd0;

      if (state != S_GAP)          gap_cnt <= '0;
      else if (tick && !gap_done)  gap_cnt <= gap_cnt + 1'b1;

      hold_full <= (hold_full & ~load_pay) | keep;
      if (keep) begin
        hold      <= i_data;
        hold_last <= i_eof;
      end

      if (state == S_GAP)  eof_seen <= 1'b0;
      else if (keep & i_eof) eof_seen <= 1'b1;

      if (do_underrun) drop <= 1'b1;
      else if (start)  drop <= 1'b0;

      if (start)         last_loaded <= 1'b0;
      else if (load_pay) last_loaded <= hold_last;

      for (int k = 0; k < LANES; k++) begin
        if (start || load_hdr)     shreg[k] <= HDR_PATTERN;
        else if (load_pay)         shreg[k] <= manchester(hold[8*k +: 8]);
`ifdef VL_TX_CRC16_EN
        else if (load_crc)         shreg[k] <= manchester(crc_word[8*k +: 8]);
`endif
        else if (tx_active & tick) shreg[k] <= {shreg[k][14:0], 1'b0};
      end
    end
  end

`ifdef VL_TX_CRC16_EN
  always_ff @(posedge i_vl_tx_clk or negedge i_vl_tx_rst_n) begin
    if (!i_vl_tx_rst_n)  crc <= 16'hFFFF;
    else if (start)      crc <= crc_upd(16'hFFFF, i_data);
    else if (keep)       crc <= crc_upd(crc, i_data);
  end
`endif

endmodule

// File: tb/tb_vl_tx_frame_serializer.sv
// Scoreboard bench for vl_tx_frame_serializer: expected chips queued at stimulus, monitors pop per cycle.
module tb_vl_tx_frame_serializer;

`ifdef VL_TX_CRC16_EN
  localparam int CRC_CH  = 32;
  localparam int CRC4_CH = 16;
`else
  localparam int CRC_CH  = 0;
  localparam int CRC4_CH = 0;
`endif

  typedef logic [7:0] bq_t [$];

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  always #5 clk = ~clk;

  logic [15:0] div1 = '0;
  logic        val1 = 1'b0, sof1 = 1'b0, eof1 = 1'b0;
  logic [7:0]  data1 = '0;
  logic        rdy1, en1, busy1, done1, und1, serr1;
  logic [0:0]  tx1;

  logic [15:0] div4 = '0;
  logic        val4 = 1'b0, sof4 = 1'b0, eof4 = 1'b0;
  logic [31:0] data4 = '0;
  logic        rdy4, en4, busy4, done4, und4, serr4;
  logic [3:0]  tx4;

  vl_tx_frame_serializer #(.LANES(1)) u1 (
    .i_vl_tx_clk(clk), .i_vl_tx_rst_n(rst_n), .i_baud_div(div1),
    .i_val(val1), .i_sof(sof1), .i_eof(eof1), .i_data(data1),
    .o_rdy(rdy1), .o_tx(tx1), .o_tx_en(en1), .o_busy(busy1),
    .o_frame_done(done1), .o_underrun(und1), .o_sof_err(serr1));

  vl_tx_frame_serializer #(.LANES(4)) u4 (
    .i_vl_tx_clk(clk), .i_vl_tx_rst_n(rst_n), .i_baud_div(div4),
    .i_val(val4), .i_sof(sof4), .i_eof(eof4), .i_data(data4),
    .o_rdy(rdy4), .o_tx(tx4), .o_tx_en(en4), .o_busy(busy4),
    .o_frame_done(done4), .o_underrun(und4), .o_sof_err(serr4));

  int n_chk = 0, n_fail = 0;
  logic       q1 [$];
  logic [3:0] q4 [$];
  int done_cnt1 = 0, und_cnt1 = 0, serr_cnt1 = 0;
  int done_cnt4 = 0, und_cnt4 = 0, serr_cnt4 = 0;
  int en_cur1 = 0, en_last1 = 0, busy_cur1 = 0, busy_last1 = 0;
  int en_cur4 = 0, en_last4 = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 'h%0h, want 'h%0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic timeout(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: timed out at %0t", name, $time);
  endtask

  function automatic logic [15:0] manch(input logic [7:0] d);
    logic [15:0] r;
    r = '0;
    for (int i = 7; i >= 0; i--) r = {r[13:0], d[i] ? 2'b10 : 2'b01};
    return r;
  endfunction

  function automatic logic [15:0] crc_b(input logic [15:0] c, input logic [7:0] d);
    logic [15:0] r;
    r = c;
    for (int i = 7; i >= 0; i--) begin
      if (r[15] ^ d[i]) r = (r << 1) ^ 16'h1021;
      else              r = r << 1;
    end
    return r;
  endfunction

  task automatic push_w1(input logic [15:0] chips, input int div);
    for (int i = 15; i >= 0; i--)
      for (int r = 0; r <= div; r++) q1.push_back(chips[i]);
  endtask

  task automatic push_hdr1(input int div);
    push_w1(16'hAAAB, div);
    push_w1(16'hAAAB, div);
  endtask

  task automatic push_w4(input logic [15:0] l0, l1, l2, l3);
    for (int i = 15; i >= 0; i--) q4.push_back({l3[i], l2[i], l1[i], l0[i]});
  endtask

  task automatic send1(input logic sof, input logic eof, input logic [7:0] d);
    int n;
    val1 = 1'b1; sof1 = sof; eof1 = eof; data1 = d;
    n = 0;
    while (!rdy1 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) timeout("send1_rdy");
    @(posedge clk);
    #1 val1 = 1'b0;
  endtask

  task automatic wait_idle1();
    int n;
    n = 0;
    while (busy1 && n < 6000) begin @(negedge clk); n++; end
    if (n >= 6000) timeout("wait_idle1");
    @(negedge clk);
  endtask

  task automatic run_frame(input bq_t b, input int div, input int mid);
    logic [15:0] c;
    c = 16'hFFFF;
    div1 = div[15:0];
    push_hdr1(div);
    foreach (b[i]) begin
      push_w1(manch(b[i]), div);
      c = crc_b(c, b[i]);
    end
`ifdef VL_TX_CRC16_EN
    push_w1(manch(c[15:8]), div);
    push_w1(manch(c[7:0]), div);
`endif
    foreach (b[i]) send1((i == 0) || (i == mid), i == b.size() - 1, b[i]);
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (en1) begin
        if (q1.size() == 0) timeout("chip1_unexpected");
        else check("chip1", 32'(tx1), 32'(q1.pop_front()));
        en_cur1++;
      end else begin
        check("idle1", 32'(tx1), 32'h0);
        if (en_cur1 != 0) en_last1 = en_cur1;
        en_cur1 = 0;
      end
      if (busy1) busy_cur1++;
      else begin
        if (busy_cur1 != 0) busy_last1 = busy_cur1;
        busy_cur1 = 0;
      end
      if (done1) done_cnt1++;
      if (und1)  und_cnt1++;
      if (serr1) serr_cnt1++;

      if (en4) begin
        if (q4.size() == 0) timeout("chip4_unexpected");
        else check("chip4", 32'(tx4), 32'(q4.pop_front()));
        en_cur4++;
      end else begin
        check("idle4", 32'(tx4), 32'h0);
        if (en_cur4 != 0) en_last4 = en_cur4;
        en_cur4 = 0;
      end
      if (done4) done_cnt4++;
      if (und4)  und_cnt4++;
      if (serr4) serr_cnt4++;
    end else begin
      en_cur1 = 0; busy_cur1 = 0; en_cur4 = 0;
    end
  end

  initial begin
    int d0, u0, s0, n;
    bq_t fb;

    repeat (3) @(negedge clk);
    check("rst_tx",   32'(tx1),   32'h0);
    check("rst_en",   32'(en1),   32'h0);
    check("rst_busy", 32'(busy1), 32'h0);
    check("rst_rdy",  32'(rdy1),  32'h0);
    check("rst_pulse", 32'({done1, und1, serr1}), 32'h0);
    check("rst_tx4",  32'(tx4),   32'h0);
    rst_n = 1'b1;
    #1 check("rdy_first_cycle", 32'(rdy1), 32'h0);
    @(posedge clk);
    #1 check("rdy_after_rst", 32'(rdy1), 32'h1);

    // single sof+eof word 0xA5
    d0 = done_cnt1;
    div1 = 16'd0;
    push_hdr1(0);
    push_w1(16'h9966, 0);
`ifdef VL_TX_CRC16_EN
    begin
      logic [15:0] c;
      c = crc_b(16'hFFFF, 8'hA5);
      push_w1(manch(c[15:8]), 0);
      push_w1(manch(c[7:0]), 0);
    end
`endif
    send1(1'b1, 1'b1, 8'hA5);
    wait_idle1();
    check("t1_en_len", 32'(en_last1), 32'(48 + CRC_CH));
    check("t1_done", 32'(done_cnt1 - d0), 32'd1);

    // div=3, four words back to back
    d0 = done_cnt1; u0 = und_cnt1;
    fb = '{8'h11, 8'h22, 8'h33, 8'h44};
    run_frame(fb, 3, -1);
    wait_idle1();
    check("t2_busy_len", 32'(busy_last1), 32'((32 + 64 + 32 + CRC_CH) * 4 + 1));
    check("t2_no_underrun", 32'(und_cnt1 - u0), 32'd0);
    check("t2_done", 32'(done_cnt1 - d0), 32'd1);

    // underrun after the third word, late eof word dropped
    d0 = done_cnt1; u0 = und_cnt1; s0 = serr_cnt1;
    div1 = 16'd0;
    push_hdr1(0);
    push_w1(manch(8'h3C), 0);
    push_w1(manch(8'hC3), 0);
    push_w1(manch(8'h5A), 0);
    send1(1'b1, 1'b0, 8'h3C);
    send1(1'b0, 1'b0, 8'hC3);
    send1(1'b0, 1'b0, 8'h5A);
    repeat (40) @(posedge clk);
    send1(1'b0, 1'b1, 8'h99);
    wait_idle1();
    check("t3_underrun", 32'(und_cnt1 - u0), 32'd1);
    check("t3_no_sof_err", 32'(serr_cnt1 - s0), 32'd0);
    check("t3_no_done", 32'(done_cnt1 - d0), 32'd0);
    d0 = done_cnt1; u0 = und_cnt1;
    fb = '{8'h7E, 8'h81};
    run_frame(fb, 0, -1);
    wait_idle1();
    check("t3_recover_done", 32'(done_cnt1 - d0), 32'd1);
    check("t3_recover_no_und", 32'(und_cnt1 - u0), 32'd0);

    // stray non-sof in IDLE, then sof on the middle word
    d0 = done_cnt1; s0 = serr_cnt1;
    send1(1'b0, 1'b0, 8'h5C);
    fb = '{8'h12, 8'h34, 8'h56};
    run_frame(fb, 0, 1);
    wait_idle1();
    check("t4_sof_err", 32'(serr_cnt1 - s0), 32'd2);
    check("t4_done", 32'(done_cnt1 - d0), 32'd1);

    // four lanes, one word 0x04030201
    div4 = 16'd0;
    push_w4(16'hAAAB, 16'hAAAB, 16'hAAAB, 16'hAAAB);
    push_w4(16'hAAAB, 16'hAAAB, 16'hAAAB, 16'hAAAB);
    push_w4(16'h5556, 16'h5559, 16'h555A, 16'h5565);
`ifdef VL_TX_CRC16_EN
    begin
      logic [15:0] c;
      c = crc_b(crc_b(crc_b(crc_b(16'hFFFF, 8'h01), 8'h02), 8'h03), 8'h04);
      push_w4(manch(c[15:8]), manch(c[7:0]), manch(8'h00), manch(8'h00));
    end
`endif
    val4 = 1'b1; sof4 = 1'b1; eof4 = 1'b1; data4 = 32'h04030201;
    n = 0;
    while (!rdy4 && n < 3000) begin @(negedge clk); n++; end
    if (n >= 3000) timeout("send4_rdy");
    @(posedge clk);
    #1 val4 = 1'b0;
    n = 0;
    while (busy4 && n < 6000) begin @(negedge clk); n++; end
    if (n >= 6000) timeout("wait_idle4");
    @(negedge clk);
    check("t5_en_len", 32'(en_last4), 32'(48 + CRC4_CH));
    check("t5_done", 32'(done_cnt4), 32'd1);
    check("t5_no_err", 32'(und_cnt4 + serr_cnt4), 32'd0);

`ifdef VL_TX_CRC16_EN
    // "123456789" -> CRC 0x29B1
    d0 = done_cnt1;
    fb = '{8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
    div1 = 16'd0;
    push_hdr1(0);
    foreach (fb[i]) push_w1(manch(fb[i]), 0);
    push_w1(manch(8'h29), 0);
    push_w1(manch(8'hB1), 0);
    foreach (fb[i]) send1(i == 0, i == fb.size() - 1, fb[i]);
    wait_idle1();
    check("t6_done", 32'(done_cnt1 - d0), 32'd1);

    // same frame, reset in the middle of the CRC trailer
    d0 = done_cnt1; u0 = und_cnt1;
    push_hdr1(0);
    foreach (fb[i]) push_w1(manch(fb[i]), 0);
    push_w1(manch(8'h29), 0);
    push_w1(manch(8'hB1), 0);
    foreach (fb[i]) send1(i == 0, i == fb.size() - 1, fb[i]);
    n = 0;
    while (en_cur1 < 196 && n < 3000) begin @(posedge clk); n++; end
    if (n >= 3000) timeout("t6_wait_crc");
    #2 rst_n = 1'b0;
    #1;
    check("t6_rst_tx",   32'(tx1),   32'h0);
    check("t6_rst_en",   32'(en1),   32'h0);
    check("t6_rst_busy", 32'(busy1), 32'h0);
    check("t6_rst_rdy",  32'(rdy1),  32'h0);
    q1.delete();
    repeat (5) @(negedge clk);
    check("t6_rst_pulses", 32'({done1, und1, serr1}), 32'h0);
    rst_n = 1'b1;
    repeat (3) @(negedge clk);
    check("t6_no_done", 32'(done_cnt1 - d0), 32'd0);
    check("t6_no_und", 32'(und_cnt1 - u0), 32'd0);
`endif

    repeat (4) @(negedge clk);
    check("q1_drained", 32'(q1.size()), 32'd0);
    check("q4_drained", 32'(q4.size()), 32'd0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
